// File: rtl/aes_mode_ctrl.sv
// -----------------------------------------------------------------------------
// aes_mode_ctrl
//
// Block-cipher mode controller (ECB / CBC / CTR) between a host block stream
// and the external AES encryption/decryption cores. One 128-bit block is
// processed at a time: accept input, run one start/done exchange with the
// selected core, present the result, repeat until the configured count is done.
//
// Ports
//   clk, reset_n            : clock, synchronous active-low reset
//   cfg_start               : pulse in IDLE to latch cfg_* and begin a message
//   cfg_mode / cfg_dir      : 00 ECB, 01 CBC, 10 CTR, 11 illegal / 0 enc, 1 dec
//   cfg_iv                  : CBC IV or CTR initial counter block
//   cfg_num_blocks          : number of blocks in the message
//   in_valid/in_ready/in_data            : input block stream
//   out_valid/out_ready/out_data/out_last: result stream
//   enc_* / dec_*           : start/done handshake with the AES cores
//   busy, done, err         : status (done/err are one-cycle pulses)
//   ctr_wrapped             : sticky, set when the CTR counter field wraps
// -----------------------------------------------------------------------------
module aes_mode_ctrl #(
    parameter int CTR_W = 32,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cfg_start,
    input  logic [1:0]       cfg_mode,
    input  logic             cfg_dir,
    input  logic [127:0]     cfg_iv,
    input  logic [LEN_W-1:0] cfg_num_blocks,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_data,
    output logic             out_last,
    output logic             enc_start,
    output logic [127:0]     enc_text,
    input  logic             enc_ready,
    input  logic             enc_done,
    input  logic [127:0]     enc_result,
    output logic             dec_start,
    output logic [127:0]     dec_text,
    input  logic             dec_ready,
    input  logic             dec_done,
    input  logic [127:0]     dec_result,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             ctr_wrapped
);

    typedef enum logic [2:0] {
        IDLE, WAIT_IN, CORE_START, CORE_WAIT, OUT, FIN
    } state_t;

    localparam logic [1:0] MODE_CBC = 2'b01;
    localparam logic [1:0] MODE_CTR = 2'b10;
    localparam logic [1:0] MODE_BAD = 2'b11;

    state_t             state_reg, state_next;
    logic [1:0]         mode_reg;
    logic               dir_reg;
    logic [127:0]       iv_reg;
    logic [LEN_W-1:0]   count_reg;
    logic [LEN_W-1:0]   idx_reg;
    logic [127:0]       chain_reg;
    logic [127:0]       blk_reg;
    logic [127:0]       text_reg;
    logic [127:0]       out_data_reg;
    logic [CTR_W-1:0]   ctr_reg;
    logic               err_reg;
    logic               wrapped_reg;
    // Zero-length messages spend one extra silent cycle in FIN so that done
    // lands two cycles after cfg_start.
    logic               zero_wait_reg;

    logic [127:0]       ctr_block;
    logic [127:0]       text_next;
    logic [127:0]       core_result;
    logic [127:0]       result;
    logic               use_enc;
    logic               sel_ready;
    logic               sel_done;
    logic               is_last;

    // Counter block: upper IV bits are frozen, low CTR_W bits are the counter.
    generate
        if (CTR_W == 128) begin : g_ctr_full
            assign ctr_block = ctr_reg;
        end else begin : g_ctr_part
            assign ctr_block = {iv_reg[127:CTR_W], ctr_reg};
        end
    endgenerate

    assign use_enc     = (mode_reg == MODE_CTR) || !dir_reg;
    assign sel_ready   = use_enc ? enc_ready  : dec_ready;
    assign sel_done    = use_enc ? enc_done   : dec_done;
    assign core_result = use_enc ? enc_result : dec_result;
    assign is_last     = (idx_reg == count_reg - LEN_W'(1));

    // Core input is computed at the input handshake and registered, so it is
    // stable for the whole start/done exchange.
    always_comb begin
        text_next = in_data;
        case (mode_reg)
            MODE_CBC: if (!dir_reg) text_next = in_data ^ chain_reg;
            MODE_CTR: text_next = ctr_block;
            default:  text_next = in_data;
        endcase
    end

    always_comb begin
        result = core_result;
        case (mode_reg)
            MODE_CBC: if (dir_reg) result = core_result ^ chain_reg;
            MODE_CTR: result = core_result ^ blk_reg;
            default:  result = core_result;
        endcase
    end

    // Next-state and FSM outputs.
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        enc_start  = 1'b0;
        dec_start  = 1'b0;
        done       = 1'b0;
        busy       = (state_reg != IDLE);
        enc_text   = use_enc ? text_reg : '0;
        dec_text   = use_enc ? '0 : text_reg;
        case (state_reg)
            IDLE: begin
                if (cfg_start && cfg_mode != MODE_BAD)
                    state_next = (cfg_num_blocks == '0) ? FIN : WAIT_IN;
            end
            WAIT_IN: begin
                in_ready = 1'b1;
                if (in_valid) state_next = CORE_START;
            end
            CORE_START: begin
                if (sel_ready) begin
                    enc_start  = use_enc;
                    dec_start  = !use_enc;
                    state_next = CORE_WAIT;
                end
            end
            CORE_WAIT: begin
                if (sel_done) state_next = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                out_last  = is_last;
                if (out_ready) state_next = is_last ? FIN : WAIT_IN;
            end
            FIN: begin
                done = !zero_wait_reg;
                if (!zero_wait_reg) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            mode_reg      <= '0;
            dir_reg       <= 1'b0;
            iv_reg        <= '0;
            count_reg     <= '0;
            idx_reg       <= '0;
            chain_reg     <= '0;
            blk_reg       <= '0;
            text_reg      <= '0;
            out_data_reg  <= '0;
            ctr_reg       <= '0;
            err_reg       <= 1'b0;
            wrapped_reg   <= 1'b0;
            zero_wait_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            err_reg   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (cfg_start) begin
                        if (cfg_mode == MODE_BAD) begin
                            err_reg <= 1'b1;
                        end else begin
                            mode_reg      <= cfg_mode;
                            dir_reg       <= cfg_dir;
                            iv_reg        <= cfg_iv;
                            count_reg     <= cfg_num_blocks;
                            chain_reg     <= cfg_iv;
                            ctr_reg       <= cfg_iv[CTR_W-1:0];
                            idx_reg       <= '0;
                            wrapped_reg   <= 1'b0;
                            zero_wait_reg <= (cfg_num_blocks == '0);
                        end
                    end
                end
                WAIT_IN: begin
                    if (in_valid) begin
                        blk_reg  <= in_data;
                        text_reg <= text_next;
                    end
                end
                CORE_WAIT: begin
                    if (sel_done) begin
                        out_data_reg <= result;
                        case (mode_reg)
                            MODE_CBC: chain_reg <= dir_reg ? blk_reg : result;
                            MODE_CTR: begin
                                ctr_reg <= ctr_reg + 1'b1;
                                if (&ctr_reg) wrapped_reg <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                OUT: begin
                    if (out_ready) idx_reg <= idx_reg + 1'b1;
                end
                FIN: zero_wait_reg <= 1'b0;
                default: ;
            endcase
        end
    end

    assign out_data    = out_data_reg;
    assign err         = err_reg;
    assign ctr_wrapped = wrapped_reg;

endmodule

// File: tb/tb_aes_mode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_aes_mode_ctrl
//
// Bench for aes_mode_ctrl. The AES cores are stand-ins: a keyed invertible
// 128-bit permutation with configurable latency and ready stalls. Expected
// outputs come from a mode-level reference (block-by-block ECB/CBC/CTR
// definitions over that permutation).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_aes_mode_ctrl;

    localparam int CTR_W = 32;
    localparam int LEN_W = 16;
    localparam logic [127:0] KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] ADDC = 128'h9e3779b97f4a7c15f39cc0605cedc834;

    logic             clk, reset_n;
    logic             cfg_start, cfg_dir;
    logic [1:0]       cfg_mode;
    logic [127:0]     cfg_iv;
    logic [LEN_W-1:0] cfg_num_blocks;
    logic             in_valid, in_ready, out_valid, out_ready, out_last;
    logic [127:0]     in_data, out_data;
    logic             enc_start, enc_ready, enc_done, dec_start, dec_ready, dec_done;
    logic [127:0]     enc_text, enc_result, dec_text, dec_result;
    logic             busy, done, err, ctr_wrapped;

    aes_mode_ctrl #(.CTR_W(CTR_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .cfg_start(cfg_start), .cfg_mode(cfg_mode), .cfg_dir(cfg_dir),
        .cfg_iv(cfg_iv), .cfg_num_blocks(cfg_num_blocks),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .enc_start(enc_start), .enc_text(enc_text), .enc_ready(enc_ready),
        .enc_done(enc_done), .enc_result(enc_result),
        .dec_start(dec_start), .dec_text(dec_text), .dec_ready(dec_ready),
        .dec_done(dec_done), .dec_result(dec_result),
        .busy(busy), .done(done), .err(err), .ctr_wrapped(ctr_wrapped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in cipher: xor key, rotate left 33, add constant (all invertible).
    function automatic logic [127:0] fenc(input logic [127:0] x);
        logic [127:0] y;
        y = x ^ KEY;
        y = {y[94:0], y[127:95]};
        return y + ADDC;
    endfunction

    function automatic logic [127:0] fdec(input logic [127:0] x);
        logic [127:0] y;
        y = x - ADDC;
        y = {y[32:0], y[127:33]};
        return y ^ KEY;
    endfunction

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- core models ----------------
    int           core_lat = 2;
    int           enc_cnt = 0, dec_cnt = 0, start_cnt = 0;
    logic [127:0] enc_hold, dec_hold;
    logic [127:0] text_seen_q[$];

    always @(posedge clk) begin
        enc_done <= 1'b0;
        if (!reset_n) begin
            enc_cnt <= 0;
        end else begin
            if (enc_cnt == 1) begin
                enc_done   <= 1'b1;
                enc_result <= fenc(enc_hold);
            end
            if (enc_cnt > 0) enc_cnt <= enc_cnt - 1;
            if (enc_start) begin
                enc_hold  <= enc_text;
                enc_cnt   <= core_lat;
                start_cnt <= start_cnt + 1;
                text_seen_q.push_back(enc_text);
            end
        end
    end

    always @(posedge clk) begin
        dec_done <= 1'b0;
        if (!reset_n) begin
            dec_cnt <= 0;
        end else begin
            if (dec_cnt == 1) begin
                dec_done   <= 1'b1;
                dec_result <= fdec(dec_hold);
            end
            if (dec_cnt > 0) dec_cnt <= dec_cnt - 1;
            if (dec_start) begin
                dec_hold  <= dec_text;
                dec_cnt   <= core_lat;
                start_cnt <= start_cnt + 1;
                text_seen_q.push_back(dec_text);
            end
        end
    end

    // ---------------- monitors ----------------
    int viol = 0;
    int done_cnt = 0;
    always @(negedge clk) begin
        if (in_ready && out_valid) viol <= viol + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    logic [127:0] pt_q[$], res_q[$], orig_q[$];

    task automatic fill_random(input int n);
        pt_q.delete();
        for (int i = 0; i < n; i++) pt_q.push_back({$urandom, $urandom, $urandom, $urandom});
    endtask

    task automatic timeout_fail(input string tag);
        chk(tag, 128'd0, 128'd1);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        reset_n   = 1'b0;
        @(negedge clk);
        reset_n   = 1'b1;
        @(negedge clk);
    endtask

    // Runs one message from pt_q; results land in res_q. Enters/exits at negedge.
    task automatic run_msg(input string name, input logic [1:0] mode, input logic dir,
                           input logic [127:0] iv, input int n, input int bp,
                           input int stall, input bit poke);
        logic [127:0] exp_q[$], xt_q[$];
        logic [127:0] chain, cb, xt, x;
        logic [63:0]  s;
        bit           exp_wrap;
        int           s0, t;
        // reference model, block by block
        chain = iv;
        for (int i = 0; i < n; i++) begin
            s  = 64'(iv[CTR_W-1:0]) + 64'(i);
            cb = {iv[127:CTR_W], s[CTR_W-1:0]};
            case (mode)
                2'b00: begin
                    xt = pt_q[i];
                    x  = dir ? fdec(pt_q[i]) : fenc(pt_q[i]);
                end
                2'b01: begin
                    if (!dir) begin
                        xt = pt_q[i] ^ chain; x = fenc(xt); chain = x;
                    end else begin
                        xt = pt_q[i]; x = fdec(pt_q[i]) ^ chain; chain = pt_q[i];
                    end
                end
                default: begin
                    xt = cb; x = fenc(cb) ^ pt_q[i];
                end
            endcase
            exp_q.push_back(x);
            xt_q.push_back(xt);
        end
        exp_wrap = (mode == 2'b10) && (n > 0) &&
                   (64'(iv[CTR_W-1:0]) + 64'(n) - 64'd1 >= 64'hffffffff);

        text_seen_q.delete();
        res_q.delete();
        s0 = start_cnt;
        cfg_mode = mode; cfg_dir = dir; cfg_iv = iv;
        cfg_num_blocks = LEN_W'(n); cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        chk({name, "_busy"}, busy, 1);
        chk({name, "_wrap_clr"}, ctr_wrapped, 0);
        if (n == 0) begin
            chk({name, "_done_t1"}, done, 0);
            @(negedge clk);
            chk({name, "_done_t2"}, done, 1);
            chk({name, "_in_ready"}, in_ready, 0);
            chk({name, "_out_valid"}, out_valid, 0);
            @(negedge clk);
            chk({name, "_idle"}, busy, 0);
            return;
        end
        for (int i = 0; i < n; i++) begin
            t = 0;
            while (!in_ready && t < 50) begin @(negedge clk); t++; end
            if (!in_ready) begin timeout_fail({name, "_in_ready_timeout"}); return; end
            if (poke && i == 0) begin
                cfg_mode = 2'b10; cfg_num_blocks = 7; cfg_iv = ~iv; cfg_start = 1'b1;
                @(negedge clk);
                cfg_start = 1'b0;
                chk({name, "_poke_wait_in"}, in_ready, 1);
            end
            if (stall > 0 && i == 0) begin enc_ready = 1'b0; dec_ready = 1'b0; end
            in_valid = 1'b1; in_data = pt_q[i];
            @(negedge clk);
            in_valid = 1'b0;
            if (stall > 0 && i == 0) begin
                repeat (stall) @(negedge clk);
                chk({name, "_stall_nostart"}, 128'(start_cnt), 128'(s0));
                enc_ready = 1'b1; dec_ready = 1'b1;
            end
            t = 0;
            while (!out_valid && t < 100) begin @(negedge clk); t++; end
            if (!out_valid) begin timeout_fail({name, "_out_valid_timeout"}); return; end
            for (int b = 0; b < bp; b++) begin
                chk($sformatf("%s_hold_data%0d", name, i), out_data, exp_q[i]);
                chk($sformatf("%s_hold_inrdy%0d", name, i), in_ready, 0);
                @(negedge clk);
            end
            chk($sformatf("%s_data%0d", name, i), out_data, exp_q[i]);
            chk($sformatf("%s_last%0d", name, i), out_last, (i == n - 1));
            res_q.push_back(out_data);
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            if (i == n - 1) chk({name, "_done"}, done, 1);
            else            chk($sformatf("%s_next_inrdy%0d", name, i), in_ready, 1);
        end
        @(negedge clk);
        chk({name, "_end_idle"}, busy, 0);
        chk({name, "_starts"}, 128'(start_cnt - s0), 128'(n));
        for (int i = 0; i < n && i < text_seen_q.size(); i++)
            chk($sformatf("%s_text%0d", name, i), text_seen_q[i], xt_q[i]);
        chk({name, "_wrap"}, ctr_wrapped, exp_wrap);
        $display("msg %s mode=%0d dir=%0d blocks=%0d", name, mode, dir, n);
    endtask

    initial begin
        int d0;
        logic [1:0] m;
        reset_n = 1'b0; cfg_start = 1'b0; cfg_mode = 2'b00; cfg_dir = 1'b0;
        cfg_iv = '0; cfg_num_blocks = '0; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b0; enc_ready = 1'b1; dec_ready = 1'b1;
        enc_result = '0; dec_result = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_done_err", {done, err, ctr_wrapped}, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // illegal mode
        cfg_mode = 2'b11; cfg_num_blocks = 3; cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        chk("err_pulse", err, 1);
        chk("err_busy", busy, 0);
        @(negedge clk);
        chk("err_one_cycle", err, 0);
        chk("err_still_idle", busy, 0);

        // zero-length message
        pt_q.delete();
        run_msg("zero", 2'b00, 1'b0, 128'h0, 0, 0, 0, 0);

        // ECB round trip
        pt_q = '{128'h3243f6a8885a308d313198a2e0370734};
        orig_q = pt_q;
        run_msg("ecb_enc", 2'b00, 1'b0, 128'h0, 1, 0, 0, 0);
        pt_q = res_q;
        run_msg("ecb_dec", 2'b00, 1'b1, 128'h0, 1, 0, 0, 0);
        chk("ecb_roundtrip", res_q[0], orig_q[0]);

        // CBC round trip
        pt_q = '{128'h6bc1bee22e409f96e93d7e117393172a, 128'hae2d8a571e03ac9c9eb76fac45af8e51};
        orig_q = pt_q;
        run_msg("cbc_enc", 2'b01, 1'b0, 128'h000102030405060708090a0b0c0d0e0f, 2, 1, 0, 0);
        pt_q = res_q;
        run_msg("cbc_dec", 2'b01, 1'b1, 128'h000102030405060708090a0b0c0d0e0f, 2, 2, 0, 0);
        for (int i = 0; i < 2; i++) chk($sformatf("cbc_roundtrip%0d", i), res_q[i], orig_q[i]);

        // CTR with the counter incrementing across the byte boundary
        pt_q = orig_q;
        run_msg("ctr", 2'b10, 1'b0, 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, 2, 0, 0, 0);
        if (text_seen_q.size() > 1)
            chk("ctr_text1", text_seen_q[1], 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00);
        else
            chk("ctr_text1_count", 128'(text_seen_q.size()), 128'd2);
        pt_q = res_q;
        run_msg("ctr_inv", 2'b10, 1'b1, 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, 2, 0, 0, 0);
        for (int i = 0; i < 2; i++) chk($sformatf("ctr_roundtrip%0d", i), res_q[i], orig_q[i]);

        // CTR counter-field wrap
        fill_random(2);
        run_msg("ctr_wrap", 2'b10, 1'b0, 128'h0123456789abcdef01234567ffffffff, 2, 0, 0, 0);
        if (text_seen_q.size() > 1)
            chk("wrap_text1", text_seen_q[1], 128'h0123456789abcdef0123456700000000);
        else
            chk("wrap_text1_count", 128'(text_seen_q.size()), 128'd2);

        // backpressure on output and core ready stall
        fill_random(2);
        run_msg("bp", 2'b00, 1'b0, 128'h0, 2, 20, 5, 0);
        fill_random(2);
        run_msg("bp_dec", 2'b01, 1'b1, {$urandom, $urandom, $urandom, $urandom}, 2, 3, 5, 0);

        // cfg_start while busy is ignored
        fill_random(2);
        run_msg("poke", 2'b01, 1'b0, {$urandom, $urandom, $urandom, $urandom}, 2, 0, 0, 1);

        // randomized messages
        for (int r = 0; r < 12; r++) begin
            core_lat = $urandom_range(1, 5);
            m = 2'($urandom_range(0, 2));
            fill_random($urandom_range(1, 4));
            run_msg($sformatf("rnd%0d", r), m, 1'($urandom_range(0, 1)),
                    {$urandom, $urandom, $urandom, ($urandom_range(0, 1) == 1) ? 32'hfffffffe : $urandom},
                    pt_q.size(), $urandom_range(0, 3), $urandom_range(0, 2), 0);
        end

        // reset during CORE_WAIT
        core_lat = 12;
        cfg_mode = 2'b00; cfg_dir = 1'b0; cfg_num_blocks = 1; cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        in_valid = 1'b1; in_data = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rstmid_in_core_wait", busy, 1);
        d0 = done_cnt;
        reset_n = 1'b0;
        @(negedge clk);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_handshake", {in_ready, out_valid, out_last, enc_start, dec_start}, 0);
        chk("rstmid_status", {done, err, ctr_wrapped}, 0);
        chk("rstmid_out_data", out_data, 0);
        chk("rstmid_enc_text", enc_text, 0);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("rstmid_no_done", 128'(done_cnt), 128'(d0));
        chk("rstmid_idle", busy, 0);
        $display("msg rst_mid_core_wait");

        core_lat = 2;
        fill_random(3);
        run_msg("recover", 2'b01, 1'b0, {$urandom, $urandom, $urandom, $urandom}, 3, 1, 0, 0);

        chk("ready_valid_excl", 128'(viol), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/aes_mode_ctrl.md
# aes_mode_ctrl

Block-cipher mode controller that sits between a host data stream and the existing AES `encryption` and `decryption` cores. It runs ECB, CBC or CTR over a configurable number of 128-bit blocks and handles chaining and counter state. Each input block triggers one start/done exchange with the selected core. Key expansion stays outside this block; the cores' `ready_enc`/`ready_dec` remain wired to `key_expansion` as today.

## Interface
- `CTR_W`, default 32: width of the CTR-mode counter field (low bits of the counter block), range 8–128.
- `LEN_W`, default 16: width of the block-count field.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `cfg_start` in 1: one-cycle pulse that latches the config and begins a message; accepted only in IDLE.
- `cfg_mode` in 2: 00 ECB, 01 CBC, 10 CTR, 11 illegal.
- `cfg_dir` in 1: 0 encrypt, 1 decrypt; ignored in CTR.
- `cfg_iv` in 128: CBC IV, or CTR initial counter block.
- `cfg_num_blocks` in LEN_W: blocks in the message.
- `in_valid` in 1, `in_ready` out 1, `in_data` in 128: input block stream.
- `out_valid` out 1, `out_ready` in 1, `out_data` out 128, `out_last` out 1: result stream.
- `enc_start` out 1, `enc_text` out 128, `enc_ready` in 1, `enc_done` in 1, `enc_result` in 128: encryption core port.
- `dec_start` out 1, `dec_text` out 128, `dec_ready` in 1, `dec_done` in 1, `dec_result` in 128: decryption core port.
- `busy` out 1: high when state ≠ IDLE.
- `done` out 1: one-cycle pulse at end of message.
- `err` out 1: one-cycle pulse on illegal mode.
- `ctr_wrapped` out 1: sticky flag; set when the counter wraps; cleared on accepted `cfg_start`.

## Operation
- FSM states: IDLE, WAIT_IN, CORE_START, CORE_WAIT, OUT, FIN.
- IDLE:
  - `cfg_start` with mode 11: pulse `err` next cycle and stay IDLE.
  - `cfg_start` with legal mode: latch mode, dir, IV and count; set chain=`cfg_iv`, ctr=`cfg_iv[CTR_W-1:0]`, idx=0.
  - Next state is WAIT_IN, or FIN if count=0.
- WAIT_IN: `in_ready`=1. On `in_valid`, capture `in_data` into `blk` and go to CORE_START.
- Core selection: CTR always uses the encryption core. ECB/CBC use the encryption core when dir=0 and the decryption core when dir=1.
- Core input, by mode:
  - ECB: `blk`.
  - CBC encrypt: `blk ^ chain`.
  - CBC decrypt: `blk`.
  - CTR: `{cfg_iv[127:CTR_W], ctr}`.
- CORE_START:
  - Hold the selected `*_text` stable from entry until `*_done`.
  - Wait for the selected `*_ready`=1, then assert `*_start` for exactly one cycle and go to CORE_WAIT.
- CORE_WAIT: on the selected `*_done`, compute the result, latch it into `out_data`, update state, and go to OUT. Results and updates by mode:
  - ECB: result = core result.
  - CBC encrypt: result = core result; chain ← result.
  - CBC decrypt: result = core result ^ chain; chain ← `blk`.
  - CTR: result = core result ^ `blk`; ctr ← ctr+1 mod 2^CTR_W; if ctr was all-ones, set `ctr_wrapped`. Upper IV bits never change.
- OUT:
  - `out_valid`=1; `out_last`=(idx==count-1).
  - On `out_ready`: idx++, then go to FIN if that was the last block, else WAIT_IN.
- FIN: `done`=1 for one cycle, then IDLE.
- Ignored inputs:
  - `cfg_start` while busy is ignored.
  - `*_done` outside CORE_WAIT is ignored.
  - The unselected core's `done` is ignored.
- Reset: all outputs 0, state IDLE, chain/ctr/idx cleared. Reset mid-message abandons it with no `done`. The cores share `reset_n`.

## Timing
- `cfg_start` at cycle t → `busy`=1 at t+1.
- Input handshake at t → CORE_START at t+1. `*_start` is asserted at t+1 if the core is ready.
- Core done at d → `out_valid` at d+1.
- Output handshake at o → `in_ready` at o+1, or `done` at o+1 for the last block.
- Per-block overhead beyond core latency: 3 cycles with zero backpressure.
- `out_data`/`out_last` are stable while `out_valid` && !`out_ready`.
- `in_ready` and `out_valid` are never high in the same cycle.
- count=0 → `done` at t+2; `in_ready` and `out_valid` stay 0.

## Test plan
All scenarios use key 2b7e151628aed2a6abf7158809cf4f3c.
- ECB encrypt, 1 block, 3243f6a8885a308d313198a2e0370734 → 3925841d02dc09fbdc118597196a0b32, with `out_last`=1 and `done` one cycle after the handshake. ECB decrypt of that result → original plaintext.
- CBC encrypt, IV 000102030405060708090a0b0c0d0e0f, 2 blocks 6bc1bee22e409f96e93d7e117393172a, ae2d8a571e03ac9c9eb76fac45af8e51 → 7649abac8119b246cee98e9b12e9197d, 5086cb9b507219ee95db113a917678b2. CBC decrypt of those → original plaintexts.
- CTR, IV f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, same 2 plaintexts → 874d6191b620e3261bef6864990db6ce, 9806f66b7970fdff8617187bb9fffdff. The second `enc_text` is f0f1f2f3f4f5f6f7f8f9fafbfcfdff00.
- CTR wrap, IV low 32 bits ffffffff, 2 blocks → second `enc_text` low 32 bits are 00000000 with upper 96 bits unchanged; `ctr_wrapped`=1 after block 1 and cleared by the next `cfg_start`.
- Backpressure: hold `out_ready`=0 for 20 cycles → `out_data` stable and `in_ready`=0 throughout. `enc_ready`=0 for 5 cycles → `enc_start` delayed, still a single-cycle pulse.
- Corner cases:
  - mode 11 → `err` pulse, `busy` stays 0.
  - count=0 → `done` only.
  - `cfg_start` while busy → ignored.
  - `reset_n`=0 during CORE_WAIT → IDLE next cycle with all outputs 0, no `done`.
